// File: rtl/bram_row_axis_reader.sv
// bram_row_axis_reader: streams BRAM rows [start_index..bound_index] onto an
// AXI4-Stream master, word 0 of each row first. Rows are prefetched into a
// two-entry ping-pong buffer, so a held tready gives gap-free output.
// Optional build macro ROW_TLAST_EN: tlast on the last word of every row
// instead of only on the final beat of the transfer.
module bram_row_axis_reader #(
   parameter int unsigned BRAM_DEPTH    = 12,
   parameter int unsigned WORD_WIDTH    = 32,
   parameter int unsigned WORDS_PER_ROW = 36,
   parameter int unsigned CNT_BITS      = 6,
   parameter int unsigned READ_LATENCY  = 2
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic                                start,
   input  logic [BRAM_DEPTH-1:0]               start_index,
   input  logic [BRAM_DEPTH-1:0]               bound_index,
   output logic                                busy,
   output logic                                done,
   output logic                                bram_en,
   output logic [BRAM_DEPTH-1:0]               bram_addr,
   input  logic [WORDS_PER_ROW*WORD_WIDTH-1:0] bram_rdata,
   output logic [WORD_WIDTH-1:0]               m_axis_tdata,
   output logic                                m_axis_tvalid,
   input  logic                                m_axis_tready,
   output logic                                m_axis_tlast
);

   localparam int unsigned ROW_W = WORDS_PER_ROW * WORD_WIDTH;

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t                  state_q, state_d;
   logic [BRAM_DEPTH-1:0]   rd_addr_q, rd_addr_d;
   logic [BRAM_DEPTH-1:0]   bound_q, bound_d;
   logic                    issue_done_q, issue_done_d;
   logic [READ_LATENCY-1:0] en_pipe_q, en_pipe_d;
   logic [READ_LATENCY-1:0] last_pipe_q, last_pipe_d;
   logic [1:0]              inflight_q, inflight_d;
   logic [ROW_W-1:0]        buf_q [2];
   logic [ROW_W-1:0]        buf_d [2];
   logic [1:0]              full_q, full_d;
   logic [1:0]              blast_q, blast_d;
   logic                    wr_sel_q, wr_sel_d;
   logic                    rd_sel_q, rd_sel_d;
   logic [CNT_BITS-1:0]     word_cnt_q, word_cnt_d;

   logic                    issue, beat, row_end, capture, cur_valid;
   logic [2:0]              occ;
   logic [WORD_WIDTH-1:0]   word_sel;

   // State registers; async reset aborts a transfer without a done pulse.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         rd_addr_q    <= '0;
         bound_q      <= '0;
         issue_done_q <= 1'b0;
         en_pipe_q    <= '0;
         last_pipe_q  <= '0;
         inflight_q   <= '0;
         buf_q[0]     <= '0;
         buf_q[1]     <= '0;
         full_q       <= '0;
         blast_q      <= '0;
         wr_sel_q     <= 1'b0;
         rd_sel_q     <= 1'b0;
         word_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         rd_addr_q    <= rd_addr_d;
         bound_q      <= bound_d;
         issue_done_q <= issue_done_d;
         en_pipe_q    <= en_pipe_d;
         last_pipe_q  <= last_pipe_d;
         inflight_q   <= inflight_d;
         buf_q        <= buf_d;
         full_q       <= full_d;
         blast_q      <= blast_d;
         wr_sel_q     <= wr_sel_d;
         rd_sel_q     <= rd_sel_d;
         word_cnt_q   <= word_cnt_d;
      end
   end

   // Next-state: FSM, read issue, capture into ping-pong buffers, beat drain.
   always_comb begin
      state_d      = state_q;
      rd_addr_d    = rd_addr_q;
      bound_d      = bound_q;
      issue_done_d = issue_done_q;
      buf_d        = buf_q;
      full_d       = full_q;
      blast_d      = blast_q;
      wr_sel_d     = wr_sel_q;
      rd_sel_d     = rd_sel_q;
      word_cnt_d   = word_cnt_q;

      cur_valid = full_q[rd_sel_q];
      beat      = cur_valid & m_axis_tready;
      row_end   = beat && (word_cnt_q == CNT_BITS'(WORDS_PER_ROW - 1));
      capture   = en_pipe_q[READ_LATENCY-1];
      // Rows held or in flight, with a buffer freed this cycle already discounted.
      occ       = 3'(full_q[0]) + 3'(full_q[1]) + 3'(inflight_q) - 3'(row_end);
      issue     = (state_q == RUN) && !issue_done_q && (occ < 3'd2);

      unique case (state_q)
         IDLE: begin
            if (start) begin
               rd_addr_d    = start_index;
               bound_d      = bound_index;
               issue_done_d = 1'b0;
               wr_sel_d     = 1'b0;
               rd_sel_d     = 1'b0;
               word_cnt_d   = '0;
               state_d      = (bound_index < start_index) ? FINISH : RUN;
            end
         end
         RUN: begin
            if (row_end && blast_q[rd_sel_q]) state_d = FINISH;
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // The last row is tracked by a flag so a bound at the top address never wraps.
      if (issue) begin
         rd_addr_d = rd_addr_q + 1'b1;
         if (rd_addr_q == bound_q) issue_done_d = 1'b1;
      end

      en_pipe_d[0]   = issue;
      last_pipe_d[0] = issue && (rd_addr_q == bound_q);
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
         en_pipe_d[i]   = en_pipe_q[i-1];
         last_pipe_d[i] = last_pipe_q[i-1];
      end
      inflight_d = inflight_q + 2'(issue) - 2'(capture);

      if (capture) begin
         buf_d[wr_sel_q]   = bram_rdata;
         full_d[wr_sel_q]  = 1'b1;
         blast_d[wr_sel_q] = last_pipe_q[READ_LATENCY-1];
         wr_sel_d          = ~wr_sel_q;
      end

      if (beat) begin
         if (row_end) begin
            word_cnt_d       = '0;
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
         end else begin
            word_cnt_d = word_cnt_q + 1'b1;
         end
      end
   end

   // Select the current word of the read-side buffer.
   always_comb begin
      word_sel = '0;
      for (int unsigned k = 0; k < WORDS_PER_ROW; k++) begin
         if (word_cnt_q == CNT_BITS'(k)) word_sel = buf_q[rd_sel_q][k*WORD_WIDTH +: WORD_WIDTH];
      end
   end

   assign busy          = (state_q != IDLE);
   assign done          = (state_q == FINISH);
   assign bram_en       = issue;
   assign bram_addr     = issue ? rd_addr_q : '0;
   assign m_axis_tvalid = cur_valid;
   assign m_axis_tdata  = cur_valid ? word_sel : '0;
`ifdef ROW_TLAST_EN
   assign m_axis_tlast  = cur_valid && (word_cnt_q == CNT_BITS'(WORDS_PER_ROW - 1));
`else
   assign m_axis_tlast  = cur_valid && blast_q[rd_sel_q] &&
                          (word_cnt_q == CNT_BITS'(WORDS_PER_ROW - 1));
`endif

endmodule

// File: tb/tb_bram_row_axis_reader.sv
// Self-checking bench for bram_row_axis_reader with a behavioural BRAM and a
// queue-based expectation of the beat stream derived from the row range.
module tb_bram_row_axis_reader;

   localparam int unsigned BD  = 12;
   localparam int unsigned WW  = 32;
   localparam int unsigned WPR = 36;
   localparam int unsigned CB  = 6;
   localparam int unsigned RL  = 2;

   logic                clk = 1'b0;
   logic                rstn, start;
   logic [BD-1:0]       start_index, bound_index;
   logic                busy, done, bram_en;
   logic [BD-1:0]       bram_addr;
   logic [WPR*WW-1:0]   bram_rdata;
   logic [WW-1:0]       m_axis_tdata;
   logic                m_axis_tvalid, m_axis_tready, m_axis_tlast;

   int unsigned total = 0;
   int unsigned bad   = 0;
   logic [31:0] seed;
   logic [BD-1:0] apipe [RL];

   always #5 clk = ~clk;

   bram_row_axis_reader #(
      .BRAM_DEPTH(BD), .WORD_WIDTH(WW), .WORDS_PER_ROW(WPR),
      .CNT_BITS(CB), .READ_LATENCY(RL)
   ) dut (
      .clk(clk), .rstn(rstn), .start(start),
      .start_index(start_index), .bound_index(bound_index),
      .busy(busy), .done(done), .bram_en(bram_en), .bram_addr(bram_addr),
      .bram_rdata(bram_rdata), .m_axis_tdata(m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] sd, input int unsigned a,
                                            input int unsigned k);
      return (a * 32'h9E3779B1) ^ (k * 32'h01000193) ^ {k[7:0], 24'h0} ^ sd;
   endfunction

   // BRAM with RL cycles of read latency.
   always_ff @(posedge clk) begin
      apipe[0] <= bram_addr;
      for (int unsigned i = 1; i < RL; i++) apipe[i] <= apipe[i-1];
   end

   always_comb begin
      bram_rdata = '0;
      for (int unsigned k = 0; k < WPR; k++)
         bram_rdata[k*WW +: WW] = mem_word(seed, 32'(apipe[RL-1]), k);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'(0));
      chk({tag, "_tlast"},  64'(m_axis_tlast),  64'(0));
      chk({tag, "_tdata"},  64'(m_axis_tdata),  64'(0));
      chk({tag, "_busy"},   64'(busy),          64'(0));
      chk({tag, "_done"},   64'(done),          64'(0));
      chk({tag, "_bram_en"}, 64'(bram_en),      64'(0));
      chk({tag, "_bram_addr"}, 64'(bram_addr),  64'(0));
   endtask

   // One transfer of rows s..b. exp_done != 0 also checks latency milestones.
   task automatic run_xfer(input int unsigned s, input int unsigned b, input int unsigned duty,
                           input int unsigned exp_done, input int unsigned abort_beat,
                           input int unsigned stray_cyc);
      logic [31:0] exp_data[$];
      bit          exp_last[$];
      int unsigned exp_addr[$];
      int unsigned n_exp, n_rows;
      int unsigned beats = 0, issued = 0, rows_done = 0, first_en = 0, first_val = 0;
      bit prev_stall = 0, finished = 0, got_done = 0, aborted = 0, beat, row_end;
      logic [31:0] prev_data = '0;
      logic        prev_last = 1'b0;

      for (int unsigned r = s; r <= b; r++) begin
         exp_addr.push_back(r);
         for (int unsigned k = 0; k < WPR; k++) begin
            exp_data.push_back(mem_word(seed, r, k));
`ifdef ROW_TLAST_EN
            exp_last.push_back(k == WPR - 1);
`else
            exp_last.push_back((r == b) && (k == WPR - 1));
`endif
         end
      end
      n_exp  = exp_data.size();
      n_rows = exp_addr.size();

      @(negedge clk);
      start_index   = s[BD-1:0];
      bound_index   = b[BD-1:0];
      start         = 1'b1;
      m_axis_tready = 1'b0;

      for (int unsigned cyc = 1; cyc <= 3000 && !finished; cyc++) begin
         @(negedge clk);
         start         = (cyc == stray_cyc);
         start_index   = BD'($urandom);
         bound_index   = BD'($urandom);
         m_axis_tready = ($urandom_range(99) < duty);
         #1;
         if (got_done) begin
            chk("busy_after_done", 64'(busy), 64'(0));
            chk("done_one_cycle", 64'(done), 64'(0));
            finished = 1;
         end else begin
            chk("busy_during", 64'(busy), 64'(1));
            beat    = m_axis_tvalid && m_axis_tready;
            row_end = 0;
            if (prev_stall) begin
               chk("stall_valid", 64'(m_axis_tvalid), 64'(1));
               chk("stall_data", 64'(m_axis_tdata), 64'(prev_data));
               chk("stall_last", 64'(m_axis_tlast), 64'(prev_last));
            end
            if (m_axis_tvalid && first_val == 0) begin
               first_val = cyc;
               if (exp_done != 0) chk("first_valid_cyc", 64'(cyc), 64'(2 + RL));
            end
            if (duty == 100 && beats > 0 && beats < n_exp)
               chk("no_gap", 64'(m_axis_tvalid), 64'(1));
            if (beat) begin
               if (exp_data.size() == 0) chk("extra_beat", 64'(beats + 1), 64'(n_exp));
               else begin
                  chk("tdata", 64'(m_axis_tdata), 64'(exp_data.pop_front()));
                  chk("tlast", 64'(m_axis_tlast), 64'(exp_last.pop_front()));
               end
               beats++;
               if (beats % WPR == 0) row_end = 1;
            end
            if (bram_en) begin
               issued++;
               if (first_en == 0) begin
                  first_en = cyc;
                  if (exp_done != 0) chk("first_en_cyc", 64'(cyc), 64'(1));
               end
               if (exp_addr.size() == 0) chk("extra_read", 64'(issued), 64'(n_rows));
               else chk("bram_addr", 64'(bram_addr), 64'(exp_addr.pop_front()));
               chk("rows_held_le2", 64'((issued - rows_done - 32'(row_end)) <= 2), 64'(1));
            end
            rows_done  += 32'(row_end);
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            if (done) begin
               got_done = 1;
               chk("done_after_last_beat", 64'(beats), 64'(n_exp));
               if (exp_done != 0) chk("done_cyc", 64'(cyc), 64'(exp_done));
            end
            if (abort_beat != 0 && beats == abort_beat) begin
               @(negedge clk);
               rstn = 1'b0;
               #1;
               check_zero("abort");
               for (int i = 0; i < 3; i++) begin
                  @(negedge clk);
                  chk("abort_no_done", 64'(done), 64'(0));
               end
               rstn     = 1'b1;
               aborted  = 1;
               finished = 1;
            end
         end
      end
      start = 1'b0;
      if (!aborted) begin
         chk("timeout", 64'(finished), 64'(1));
         chk("beat_count", 64'(beats), 64'(n_exp));
         chk("read_count", 64'(issued), 64'(n_rows));
      end
   endtask

   initial begin
      int unsigned s, b;
      seed          = $urandom;
      rstn          = 1'b0;
      start         = 1'b0;
      start_index   = '0;
      bound_index   = '0;
      m_axis_tready = 1'b0;
      #1;
      check_zero("reset");
      repeat (3) @(negedge clk);
      rstn = 1'b1;

      run_xfer(5, 5, 100, 40, 0, 0);          // single row, latency milestones
      run_xfer(0, 3, 100, 0, 0, 0);           // four rows, gap-free
      run_xfer(0, 3, 30, 0, 0, 0);            // same range under backpressure
      run_xfer(4095, 4095, 100, 0, 0, 0);     // top address, no wrap
      run_xfer(10, 9, 100, 1, 0, 1);          // empty range, stray start in FINISH
      run_xfer(20, 21, 60, 0, 0, 15);         // start while busy is dropped
      run_xfer(7, 8, 100, 0, 20, 0);          // async reset at beat 20
      run_xfer(7, 8, 100, 0, 0, 0);           // fresh run after abort
      for (int i = 0; i < 4; i++) begin
         s = $urandom_range(4095);
         b = s + $urandom_range(2);
         if (b > 4095) b = 4095;
         run_xfer(s, b, $urandom_range(100, 20), 0, 0, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
